// File: rtl/alu_issue_stage.sv
// ALU issue stage: single-entry skid-free pipeline register in front of the ALU.
// Resolves operand forwarding at capture and keeps held operands coherent while stalled.
module alu_issue_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rs_idx,
   input  logic [4:0]  in_rt_idx,
   input  logic [4:0]  in_rd_idx,
   input  logic [31:0] in_rs_data,
   input  logic [31:0] in_rt_data,
   input  logic [5:0]  in_funct,
   input  logic [15:0] in_imm,
   input  logic        in_use_imm,
   input  logic        fwd1_we,
   input  logic [4:0]  fwd1_idx,
   input  logic [31:0] fwd1_data,
   input  logic        fwd2_we,
   input  logic [4:0]  fwd2_idx,
   input  logic [31:0] fwd2_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] read1,
   output logic [31:0] foutput,
   output logic [5:0]  control,
   output logic [4:0]  out_rd_idx,
   output logic        illegal,
   output logic [15:0] issue_cnt
);

   logic        valid_q, valid_d;
   logic [31:0] op1_q, op1_d;
   logic [31:0] op2_q, op2_d;
   logic [5:0]  ctl_q, ctl_d;
   logic [4:0]  rd_q, rd_d;
   logic [4:0]  rs_q, rs_d;
   logic [4:0]  rt_q, rt_d;
   logic        imm_q, imm_d;
   logic        ill_q, ill_d;
   logic [15:0] cnt_q, cnt_d;

   logic capture;
   logic handshake;

   // EX/MEM wins over MEM/WB; register 0 is hardwired and never forwarded.
   function automatic logic [31:0] resolve(input logic [4:0]  idx,
                                           input logic [31:0] dflt,
                                           input logic        we1,
                                           input logic [4:0]  idx1,
                                           input logic [31:0] data1,
                                           input logic        we2,
                                           input logic [4:0]  idx2,
                                           input logic [31:0] data2);
      logic [31:0] r;
      r = dflt;
      if (idx != 5'd0) begin
         if (we1 && (idx1 == idx))      r = data1;
         else if (we2 && (idx2 == idx)) r = data2;
      end
      return r;
   endfunction

   function automatic logic is_legal(input logic [5:0] f);
      logic ok;
      case (f)
         6'd16, 6'd34, 6'd35, 6'd36, 6'd39, 6'd42: ok = 1'b1;
         default:                                  ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign in_ready  = !valid_q || out_ready;
   assign capture   = in_valid && in_ready && !flush;
   assign handshake = valid_q && out_ready;

   always_comb begin
      valid_d = valid_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      ctl_d   = ctl_q;
      rd_d    = rd_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      imm_d   = imm_q;
      ill_d   = ill_q;
      cnt_d   = cnt_q + {15'd0, handshake};

      if (flush) begin
         valid_d = 1'b0;
      end else if (capture) begin
         valid_d = 1'b1;
         op1_d   = resolve(in_rs_idx, in_rs_data, fwd1_we, fwd1_idx, fwd1_data,
                           fwd2_we, fwd2_idx, fwd2_data);
         op2_d   = in_use_imm ? {{16{in_imm[15]}}, in_imm}
                              : resolve(in_rt_idx, in_rt_data, fwd1_we, fwd1_idx, fwd1_data,
                                        fwd2_we, fwd2_idx, fwd2_data);
         ctl_d   = in_funct;
         rd_d    = in_rd_idx;
         rs_d    = in_rs_idx;
         rt_d    = in_rt_idx;
         imm_d   = in_use_imm;
         ill_d   = !is_legal(in_funct);
      end else if (handshake) begin
         valid_d = 1'b0;
      end else if (valid_q) begin
         // Stalled: track later-stage writes to the held sources.
         op1_d = resolve(rs_q, op1_q, fwd1_we, fwd1_idx, fwd1_data,
                         fwd2_we, fwd2_idx, fwd2_data);
         if (!imm_q)
            op2_d = resolve(rt_q, op2_q, fwd1_we, fwd1_idx, fwd1_data,
                            fwd2_we, fwd2_idx, fwd2_data);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         op1_q   <= '0;
         op2_q   <= '0;
         ctl_q   <= '0;
         rd_q    <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         imm_q   <= 1'b0;
         ill_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         ctl_q   <= ctl_d;
         rd_q    <= rd_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         imm_q   <= imm_d;
         ill_q   <= ill_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid  = valid_q;
   assign read1      = op1_q;
   assign foutput    = op2_q;
   assign control    = ctl_q;
   assign out_rd_idx = rd_q;
   assign illegal    = ill_q;
   assign issue_cnt  = cnt_q;

endmodule
